// File: rtl/ctrl_pipeline_seq.sv
// Instruction-dispatch pipeline sequencer: STAGES-deep opcode shift pipe with fetch handshake, stall, flush, halt-drain FSM and retired counter.
// Latency: opcode accepted at edge k appears in stage i after edge k+i; each stalled cycle adds one.
// Backpressure: INSTR_READY drops combinationally on STALL, FLUSH, reset, or outside RUN (draining a HALT or halted).
//
// Ports:
//   CLK, RST_bar             clock, synchronous active-low reset
//   INSTR_IN/_VALID/_READY   fetch handshake from the memory data bus; PC_INC = accepted
//   STALL, FLUSH             hold all stages / squash all stages (FLUSH wins)
//   STAGE_INSTR/_VALID       per-stage opcode and valid, stage i at [i*INSTR_WIDTH +: INSTR_WIDTH]
//   HALT, RETIRED_COUNT      halted flag, saturating count of retired valid instructions
module ctrl_pipeline_seq #(
    parameter int                     STAGES      = 2,
    parameter int                     INSTR_WIDTH = 8,
    parameter logic [INSTR_WIDTH-1:0] NOP_OPCODE  = '0,
    parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = 8'hFF,
    parameter int                     COUNT_WIDTH = 16
) (
    input  logic                          CLK,
    input  logic                          RST_bar,
    input  logic [INSTR_WIDTH-1:0]        INSTR_IN,
    input  logic                          INSTR_VALID,
    output logic                          INSTR_READY,
    input  logic                          STALL,
    input  logic                          FLUSH,
    output logic                          PC_INC,
    output logic [STAGES*INSTR_WIDTH-1:0] STAGE_INSTR,
    output logic [STAGES-1:0]             STAGE_VALID,
    output logic                          HALT,
    output logic [COUNT_WIDTH-1:0]        RETIRED_COUNT
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [INSTR_WIDTH-1:0] op_q [STAGES];
    logic [STAGES-1:0]      vld_q;
    logic [COUNT_WIDTH-1:0] count_q;

    logic accept;
    logic advance;
    logic retire;
    logic last_is_halt;

    assign INSTR_READY  = (state == ST_RUN) & ~STALL & ~FLUSH & RST_bar;
    assign accept       = INSTR_VALID & INSTR_READY;
    assign PC_INC       = accept;
    assign advance      = (state != ST_HALTED) & ~STALL & ~FLUSH;
    // A flush still lets the last stage retire; a stall does not.
    assign retire       = vld_q[STAGES-1] & (advance | FLUSH) & (state != ST_HALTED);
    assign last_is_halt = (op_q[STAGES-1] == HALT_OPCODE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN, ST_DRAIN: begin
                // Retiring HALT wins; a flush in DRAIN has squashed the HALT so fetching resumes.
                if (retire && last_is_halt) begin
                    state_nxt = ST_HALTED;
                end else if (FLUSH) begin
                    state_nxt = ST_RUN;
                end else if (accept && (INSTR_IN == HALT_OPCODE)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_bar) begin
            state   <= ST_RUN;
            vld_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                op_q[i] <= NOP_OPCODE;
            end
        end else begin
            state <= state_nxt;
            if ((state != ST_HALTED) && FLUSH) begin
                vld_q <= '0;
                for (int i = 0; i < STAGES; i++) begin
                    op_q[i] <= NOP_OPCODE;
                end
            end else if (advance) begin
                for (int i = STAGES - 1; i > 0; i--) begin
                    op_q[i]  <= op_q[i-1];
                    vld_q[i] <= vld_q[i-1];
                end
                op_q[0]  <= accept ? INSTR_IN : NOP_OPCODE;
                vld_q[0] <= accept;
            end
            // Saturate rather than wrap.
            if (retire && (count_q != {COUNT_WIDTH{1'b1}})) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage_out
        assign STAGE_INSTR[g*INSTR_WIDTH +: INSTR_WIDTH] = op_q[g];
    end

    assign STAGE_VALID   = vld_q;
    assign HALT          = (state == ST_HALTED);
    assign RETIRED_COUNT = count_q;

endmodule
